// File: rtl/alarm_pkg.sv
// Shared alarm-path definitions: update FSM states and default array geometry
// common to the synchronizer and the settling stage.
package alarm_pkg;

    localparam int ARRAY_W_DEF = 9;
    localparam int DATA_W_DEF  = 12;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } upd_state_e;

    typedef logic [DATA_W_DEF-1:0] entry_t;

endpackage

// File: rtl/settle_cell.sv
// One array entry: accepts a new value only after it has held for STABLE_CYC
// consecutive equal compares, and pulses commit_o on the edge it is taken.
module settle_cell #(
    parameter int DATA_W     = 12,
    parameter int STABLE_CYC = 4
) (
    input  logic              clk_sync_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] settled_o,
    output logic              commit_o
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);

    logic [DATA_W-1:0] prev;
    logic [CNT_W-1:0]  cnt;
    logic              same;

    assign same = (data_i == prev);

    // Saturating cnt means cnt==CNT_LAST is hit once per steady run, so one commit per run.
    assign commit_o = same && (cnt == CNT_LAST) && (prev != settled_o);

    always_ff @(posedge clk_sync_i or posedge rst_i) begin
        if (rst_i) begin
            prev      <= '0;
            cnt       <= '0;
            settled_o <= '0;
        end else begin
            prev <= data_i;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (commit_o) begin
                settled_o <= prev;
            end
        end
    end

endmodule

// File: rtl/data_settle.sv
// Settling stage: per-entry stability filter plus a round-robin publisher that
// streams committed (index, data) updates over a valid/ready handshake.
//
//   state   | meaning
//   IDLE    | no update presented; scan pending from rr_ptr for the next entry
//   PRESENT | upd_idx_o/upd_data_o held with upd_valid_o until upd_ready_i
module data_settle
    import alarm_pkg::*;
#(
    parameter int  ARRAY_W    = ARRAY_W_DEF,
    parameter int  DATA_W     = DATA_W_DEF,
    parameter int  STABLE_CYC = 4,
    localparam int IDX_W      = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1
) (
    input  logic                           clk_sync_i,
    input  logic                           rst_i,
    input  logic [ARRAY_W-1:0][DATA_W-1:0] sync_data_i,
    output logic [ARRAY_W-1:0][DATA_W-1:0] settled_data_o,
    output logic [ARRAY_W-1:0]             pending_o,
    output logic                           upd_valid_o,
    output logic [IDX_W-1:0]               upd_idx_o,
    output logic [DATA_W-1:0]              upd_data_o,
    input  logic                           upd_ready_i
);

    logic [ARRAY_W-1:0] commit_vec;
    logic [ARRAY_W-1:0] clr_vec;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W:0]     scan_idx;
    logic               pick_found;
    logic               accept;
    upd_state_e         state;

    for (genvar i = 0; i < ARRAY_W; i++) begin : g_cell
        settle_cell #(
            .DATA_W     (DATA_W),
            .STABLE_CYC (STABLE_CYC)
        ) u_cell (
            .clk_sync_i (clk_sync_i),
            .rst_i      (rst_i),
            .data_i     (sync_data_i[i]),
            .settled_o  (settled_data_o[i]),
            .commit_o   (commit_vec[i])
        );
    end

    assign accept  = upd_valid_o && upd_ready_i;
    assign clr_vec = accept ? (ARRAY_W'(1) << upd_idx_o) : '0;

    // First set pending bit at or after rr_ptr, wrapping past the last entry.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < ARRAY_W; k++) begin
            scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(ARRAY_W)) begin
                scan_idx = scan_idx - (IDX_W+1)'(ARRAY_W);
            end
            if (!pick_found && pending_o[scan_idx[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_sync_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pending_o   <= '0;
            rr_ptr      <= '0;
            upd_valid_o <= 1'b0;
            upd_idx_o   <= '0;
            upd_data_o  <= '0;
        end else begin
            // A commit on the accept edge of the same entry keeps it pending.
            pending_o <= (pending_o & ~clr_vec) | commit_vec;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        upd_idx_o   <= pick_idx;
                        upd_data_o  <= settled_data_o[pick_idx];
                        upd_valid_o <= 1'b1;
                        state       <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        upd_valid_o <= 1'b0;
                        rr_ptr      <= (upd_idx_o == IDX_W'(ARRAY_W - 1)) ? '0 : upd_idx_o + 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_settle.sv
// Self-checking bench for data_settle: directed scenarios plus a random phase,
// all compared against a run-length / transaction-level reference model.
module tb_data_settle;
    import alarm_pkg::*;

    localparam int AW = ARRAY_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int SC = 4;
    localparam int IW = $clog2(AW);

    logic                   clk_sync_i = 1'b0;
    logic                   rst_i      = 1'b1;
    logic [AW-1:0][DW-1:0]  sync_d     = '0;
    logic                   rdy        = 1'b0;
    logic [AW-1:0][DW-1:0]  settled_data_o;
    logic [AW-1:0]          pending_o;
    logic                   upd_valid_o;
    logic [IW-1:0]          upd_idx_o;
    logic [DW-1:0]          upd_data_o;

    data_settle #(.ARRAY_W(AW), .DATA_W(DW), .STABLE_CYC(SC)) dut (
        .clk_sync_i     (clk_sync_i),
        .rst_i          (rst_i),
        .sync_data_i    (sync_d),
        .settled_data_o (settled_data_o),
        .pending_o      (pending_o),
        .upd_valid_o    (upd_valid_o),
        .upd_idx_o      (upd_idx_o),
        .upd_data_o     (upd_data_o),
        .upd_ready_i    (rdy)
    );

    always #5 clk_sync_i = ~clk_sync_i;

    int     n_assert = 0;
    int     n_fail   = 0;

    // Reference model: per-entry run length of the current input value.
    entry_t m_last [AW];
    entry_t m_set  [AW];
    int     m_run  [AW];
    bit     m_pend [AW];
    bit     m_valid;
    int     m_idx;
    entry_t m_data;
    int     m_rr;

    int     obs_idx  [$];
    entry_t obs_data [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < AW; i++) begin
            m_last[i] = '0;
            m_run[i]  = 1;
            m_set[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_idx   = 0;
        m_data  = '0;
        m_rr    = 0;
    endtask

    task automatic model_edge();
        bit c [AW];
        bit found;
        int j;
        for (int i = 0; i < AW; i++) begin
            if (sync_d[i] == m_last[i]) m_run[i]++;
            else                        m_run[i] = 1;
            m_last[i] = sync_d[i];
            c[i] = (m_run[i] == SC + 1) && (sync_d[i] != m_set[i]);
        end
        if (m_valid) begin
            if (rdy) begin
                m_valid      = 1'b0;
                m_pend[m_idx] = 1'b0;
                m_rr         = (m_idx + 1) % AW;
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < AW; k++) begin
                j = (m_rr + k) % AW;
                if (!found && m_pend[j]) begin
                    found   = 1'b1;
                    m_idx   = j;
                    m_data  = m_set[j];
                    m_valid = 1'b1;
                end
            end
        end
        for (int i = 0; i < AW; i++) begin
            if (c[i]) begin
                m_pend[i] = 1'b1;
                m_set[i]  = sync_d[i];
            end
        end
    endtask

    task automatic compare_all();
        logic [AW-1:0][DW-1:0] es;
        logic [AW-1:0]         ep;
        for (int i = 0; i < AW; i++) begin
            es[i] = m_set[i];
            ep[i] = m_pend[i];
        end
        chk("settled", settled_data_o, es);
        chk("pending", pending_o, ep);
        chk("valid", upd_valid_o, m_valid);
        if (m_valid) begin
            chk("idx", upd_idx_o, m_idx);
            chk("data", upd_data_o, m_data);
        end
    endtask

    task automatic step();
        if (upd_valid_o && rdy) begin
            obs_idx.push_back(int'(upd_idx_o));
            obs_data.push_back(upd_data_o);
        end
        @(posedge clk_sync_i);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int k = 0;
        while (!upd_valid_o && k < maxc) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, upd_valid_o, 1'b1);
    endtask

    initial begin
        int     n0;
        bit     any_v;
        entry_t v1, v2, v7, v8, v0, v4;

        model_reset();
        rst_i = 1'b1;
        rdy   = 1'b0;
        #12;
        chk("rst_valid", upd_valid_o, 1'b0);
        chk("rst_settled", settled_data_o, '0);
        chk("rst_pending", pending_o, '0);
        chk("rst_idx", upd_idx_o, '0);
        chk("rst_data", upd_data_o, '0);
        @(negedge clk_sync_i);
        rst_i = 1'b0;
        rdy   = 1'b1;
        repeat (10) step();
        chk("idle_no_upd", obs_idx.size(), 0);

        // Single change with exact latency.
        sync_d[3] = 12'hABC;
        repeat (4) step();
        chk("e4_settled", settled_data_o[3], 12'h000);
        step();
        chk("e5_settled", settled_data_o[3], 12'hABC);
        chk("e5_pend", pending_o[3], 1'b1);
        chk("e5_valid", upd_valid_o, 1'b0);
        step();
        chk("e6_valid", upd_valid_o, 1'b1);
        chk("e6_idx", upd_idx_o, 3);
        chk("e6_data", upd_data_o, 12'hABC);
        n0 = obs_idx.size();
        repeat (6) step();
        chk("single_count", obs_idx.size() - n0, 1);

        // Glitch filter on entry 0.
        any_v = 1'b0;
        for (int c = 0; c < 40; c++) begin
            sync_d[0] = ((c / 2) % 2) ? 12'h002 : 12'h001;
            step();
            if (upd_valid_o) any_v = 1'b1;
        end
        chk("glitch_no_valid", any_v, 1'b0);
        chk("glitch_no_commit", settled_data_o[0], 12'h000);
        n0 = obs_idx.size();
        repeat (10) step();
        chk("glitch_final_count", obs_idx.size() - n0, 1);
        chk("glitch_final_val", settled_data_o[0], 12'h002);

        // Round-robin with wrap: move rr_ptr to 5 via entry 4, then 8/0/4 together.
        sync_d[4] = m_set[4] ^ 12'($urandom_range(1, 4095));
        n0 = obs_idx.size();
        repeat (10) step();
        chk("rr_prep_count", obs_idx.size() - n0, 1);
        v8 = m_set[8] ^ 12'($urandom_range(1, 4095));
        v0 = m_set[0] ^ 12'($urandom_range(1, 4095));
        v4 = m_set[4] ^ 12'($urandom_range(1, 4095));
        sync_d[8] = v8;
        sync_d[0] = v0;
        sync_d[4] = v4;
        n0 = obs_idx.size();
        repeat (20) step();
        chk("rr_count", obs_idx.size() - n0, 3);
        chk("rr_first", obs_idx[n0], 8);
        chk("rr_second", obs_idx[n0+1], 0);
        chk("rr_third", obs_idx[n0+2], 4);
        chk("rr_data8", obs_data[n0], v8);
        chk("rr_data0", obs_data[n0+1], v0);
        chk("rr_data4", obs_data[n0+2], v4);
        sync_d[3] = m_set[3] ^ 12'($urandom_range(1, 4095));
        sync_d[6] = m_set[6] ^ 12'($urandom_range(1, 4095));
        n0 = obs_idx.size();
        repeat (20) step();
        chk("rr_end_count", obs_idx.size() - n0, 2);
        chk("rr_end_first", obs_idx[n0], 6);
        chk("rr_end_second", obs_idx[n0+1], 3);

        // Backpressure: presented update frozen while new commits queue up.
        rdy = 1'b0;
        v1 = 12'h800 | 12'($urandom_range(0, 2047));
        v2 = 12'h800 | 12'($urandom_range(0, 2047));
        v7 = 12'h800 | 12'($urandom_range(0, 2047));
        sync_d[1] = v1;
        wait_valid("bp", 12);
        for (int c = 0; c < 20; c++) begin
            if (c == 2) begin
                sync_d[2] = v2;
                sync_d[7] = v7;
            end
            step();
            chk("bp_valid", upd_valid_o, 1'b1);
            chk("bp_idx", upd_idx_o, 1);
            chk("bp_data", upd_data_o, v1);
        end
        chk("bp_pend2", pending_o[2], 1'b1);
        chk("bp_pend7", pending_o[7], 1'b1);
        rdy = 1'b1;
        n0 = obs_idx.size();
        repeat (20) step();
        chk("bp_count", obs_idx.size() - n0, 3);
        chk("bp_order0", obs_idx[n0], 1);
        chk("bp_order1", obs_idx[n0+1], 2);
        chk("bp_order2", obs_idx[n0+2], 7);
        chk("bp_drained", pending_o, '0);

        // Commit on the accept edge of the same entry.
        rdy = 1'b0;
        sync_d[2] = 12'h044;
        wait_valid("col", 12);
        chk("col_idx", upd_idx_o, 2);
        chk("col_data", upd_data_o, 12'h044);
        sync_d[2] = 12'h055;
        repeat (4) step();
        rdy = 1'b1;
        step();
        chk("col_pend", pending_o[2], 1'b1);
        chk("col_valid", upd_valid_o, 1'b0);
        chk("col_settled", settled_data_o[2], 12'h055);
        wait_valid("col2", 4);
        chk("col2_idx", upd_idx_o, 2);
        chk("col2_data", upd_data_o, 12'h055);
        repeat (4) step();

        // Random traffic with values drawn from a small pool to force returns.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0:       sync_d[$urandom_range(0, AW-1)] = 12'h000;
                    1:       sync_d[$urandom_range(0, AW-1)] = 12'h111;
                    2:       sync_d[$urandom_range(0, AW-1)] = 12'h222;
                    default: sync_d[$urandom_range(0, AW-1)] = 12'h333;
                endcase
            end
            rdy = ($urandom_range(0, 2) != 0);
            step();
        end
        rdy = 1'b1;
        repeat (40) step();
        chk("rand_drained", pending_o, '0);
        chk("rand_idle", upd_valid_o, 1'b0);

        // Reset in the middle of a handshake drops the update.
        rdy = 1'b0;
        sync_d[5] = m_set[5] ^ 12'($urandom_range(1, 4095));
        wait_valid("mid", 12);
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", upd_valid_o, 1'b0);
        chk("mid_rst_settled", settled_data_o, '0);
        chk("mid_rst_pending", pending_o, '0);
        chk("mid_rst_idx", upd_idx_o, '0);
        chk("mid_rst_data", upd_data_o, '0);
        model_reset();
        sync_d = '0;
        @(negedge clk_sync_i);
        rst_i = 1'b0;
        rdy   = 1'b1;
        n0 = obs_idx.size();
        repeat (12) step();
        chk("no_replay", obs_idx.size() - n0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_settle.md
# data_settle

Settling stage downstream of the array synchronizer. It takes the flop-synchronized ARRAY_W×DATA_W array in the clk_sync_i domain. A per-entry multi-bit value is accepted only after it has held steady for a programmable number of cycles, which filters skewed bits left by the flop-only crossing. Each accepted change is published as a settled array and as a stream of (index, data) updates over a valid/ready handshake to the display/alarm logic.

## Interface
- ARRAY_W, 9, number of array entries
- DATA_W, 12, bits per entry
- STABLE_CYC, 4, consecutive equal compares required before commit (≥1)
- IDX_W, $clog2(ARRAY_W), width of update index (derived, not overridden)
- clk_sync_i  in  1  clock
- rst_i  in  1  reset: asynchronous, active-high
- sync_data_i  in  [ARRAY_W-1:0][DATA_W-1:0]  synchronizer output
- settled_data_o  out  [ARRAY_W-1:0][DATA_W-1:0]  last committed value per entry
- pending_o  out  ARRAY_W  entry committed but not yet accepted downstream
- upd_valid_o  out  1  update available
- upd_idx_o  out  IDX_W  index of presented update
- upd_data_o  out  DATA_W  data of presented update
- upd_ready_i  in  1  downstream accepts when high with upd_valid_o

## Operation
- Per entry i: registers prev[i], cnt[i] (0..STABLE_CYC, saturating), settled[i], pending[i].
- Every edge: prev[i] <= sync_data_i[i]; if sync_data_i[i] != prev[i], cnt[i] <= 0, else cnt[i] <= min(cnt[i]+1, STABLE_CYC).
- Commit: on an edge where sync_data_i[i]==prev[i], cnt[i]==STABLE_CYC-1, and prev[i]!=settled[i], then settled[i] <= prev[i] and pending[i] <= 1. Saturation guarantees one commit per stable run.
- A value returning to the current settled[i] produces no commit and no pending.
- Output FSM, states IDLE and PRESENT:
  - IDLE: if any pending, pick the first set pending bit scanning from rr_ptr upward with wrap at ARRAY_W-1 → 0. Capture idx and settled[idx] into upd_idx_o/upd_data_o, assert upd_valid_o, go to PRESENT. Otherwise stay.
  - PRESENT: hold idx/data/valid stable until upd_valid_o && upd_ready_i. On accept: valid <= 0, pending[idx] <= 0, rr_ptr <= (idx==ARRAY_W-1) ? 0 : idx+1, go to IDLE.
- Commit to entry idx on the same edge as its accept: the commit wins, pending stays 1, and the new value is presented on a later pass. The captured upd_data_o is never modified while valid.
- upd_ready_i without upd_valid_o is ignored.
- Multiple simultaneous commits all set their pending bits.

## Timing
- Reset (async assert, sync-safe release): prev, cnt, settled, pending, rr_ptr, upd_idx_o, upd_data_o = 0; upd_valid_o = 0; FSM = IDLE. Reset mid-handshake drops the update with no replay.
- Latency: a new value X must be present at sync_data_i for STABLE_CYC+1 consecutive edges. settled_data_o and pending_o update on edge STABLE_CYC+1. upd_valid_o rises on edge STABLE_CYC+2 if the FSM is idle.
- Throughput: at most one update per 2 cycles, with a mandatory IDLE bubble after each accept.
- STABLE_CYC=1: commit on the second edge of a steady value.
- pending_o and settled_data_o are direct register outputs with no combinational path from inputs.

## Structure
- Shared project package (alarm_pkg) holds: the FSM state enum typedef (IDLE, PRESENT), default ARRAY_W/DATA_W constants shared with the synchronizer, and the entry data typedef logic [DATA_W-1:0].
- One sub-module: settle_cell, containing prev/cnt/settled/commit logic for one entry. It is generated ARRAY_W times and outputs settled value and commit pulse.
- Top level contains the pending vector, round-robin picker, and output FSM.

## Test plan
- Reset: hold rst_i mid-run → all outputs 0 within the same cycle, upd_valid_o=0. Release → no updates with input all-zero.
- Single change: entry 3 := 12'hABC held 5 cycles (STABLE_CYC=4), ready=1 → settled[3]=12'hABC on edge 5, then exactly one update (idx 3, 12'hABC) with valid on edge 6.
- Glitch filter: entry 0 toggles 12'h001/12'h002 every 2 cycles for 40 cycles → no commit, no upd_valid_o. A final steady value commits once.
- Round-robin and wrap: entries 8, 0, 4 commit the same edge with rr_ptr=5 → order 8, 0, 4. rr_ptr ends at 5.
- Backpressure: ready=0 for 20 cycles with valid high → idx/data constant. Entry commits during the stall are held pending and delivered after ready=1.
- Commit/accept collision: entry 2 recommits to 12'h055 on the accept edge of its update 12'h044 → pending[2] stays 1. Next update is (2, 12'h055).
